// File: rtl/hunt_round_ctrl.sv
// hunt_round_ctrl
// Round controller for a shooting-gallery game. It sequences a start countdown,
// the hunting phase with magazine/reserve bookkeeping, timed reloads, a post-kill
// delay that fires a one-cycle dog trigger, and the game-over hold.
//
// Ports
//   clk, rst            clock (posedge) and synchronous active-high reset
//   game_enable         level; low returns the controller to IDLE from any state
//   mouse_xpos/ypos     cursor position (12 bit each)
//   left_mouse          fire button level, acted on at its rising edge
//   right_mouse         reload button level, acted on at its rising edge
//   tgt_xpos/ypos       packed target origins, target i at [12i+11:12i]
//   tgt_alive           per-target hittable flag
//   mag, reserve        rounds in magazine / rounds in reserve
//   score               kill count, saturates at 127
//   hit_vec             one-hot, one-cycle kill pulse (lowest index wins)
//   hunt_active         high in HUNTING and RELOADING
//   reloading           high in RELOADING
//   show_reload         magazine empty and game not over
//   dog_pulse           one-cycle trigger during the post-kill delay
//   game_over           high in OVER
// All outputs come straight from registers.

module hunt_round_ctrl #(
    parameter int N_TGT      = 2,
    parameter int TGT_W      = 96,
    parameter int TGT_H      = 60,
    parameter int MAG_SIZE   = 3,
    parameter int RESERVE    = 15,
    parameter int START_CYC  = 487_500_000,
    parameter int KILL_CYC   = 292_500_000,
    parameter int DOG_CYC    = 162_500_000,
    parameter int RELOAD_CYC = 32_500_000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               game_enable,
    input  logic [11:0]                        mouse_xpos,
    input  logic [11:0]                        mouse_ypos,
    input  logic                               left_mouse,
    input  logic                               right_mouse,
    input  logic [12*N_TGT-1:0]                tgt_xpos,
    input  logic [12*N_TGT-1:0]                tgt_ypos,
    input  logic [N_TGT-1:0]                   tgt_alive,
    output logic [$clog2(MAG_SIZE+1)-1:0]      mag,
    output logic [$clog2(RESERVE+1)-1:0]       reserve,
    output logic [6:0]                         score,
    output logic [N_TGT-1:0]                   hit_vec,
    output logic                               hunt_active,
    output logic                               reloading,
    output logic                               show_reload,
    output logic                               dog_pulse,
    output logic                               game_over
);

    localparam int MW      = $clog2(MAG_SIZE+1);
    localparam int RW      = $clog2(RESERVE+1);
    localparam int CW      = (MW > RW) ? MW : RW;
    localparam int MAX_A   = (START_CYC > KILL_CYC) ? START_CYC : KILL_CYC;
    localparam int MAX_CYC = (MAX_A > RELOAD_CYC) ? MAX_A : RELOAD_CYC;
    localparam int TW      = $clog2(MAX_CYC+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_HUNTING,
        S_RELOADING,
        S_KILL_DELAY,
        S_OVER
    } stateT;

    stateT             r_state;
    logic [MW-1:0]     r_mag;
    logic [RW-1:0]     r_reserve;
    logic [6:0]        r_score;
    logic [TW-1:0]     r_timer;
    logic              r_leftPrev;
    logic              r_rightPrev;
    logic [N_TGT-1:0]  r_hitVec;
    logic              r_huntActive;
    logic              r_reloading;
    logic              r_showReload;
    logic              r_dogPulse;
    logic              r_gameOver;

    stateT             w_nextState;
    logic [MW-1:0]     w_nextMag;
    logic [RW-1:0]     w_nextReserve;
    logic [6:0]        w_nextScore;
    logic [TW-1:0]     w_nextTimer;
    logic [N_TGT-1:0]  w_nextHitVec;
    logic              w_nextHuntActive;
    logic              w_nextReloading;
    logic              w_nextShowReload;
    logic              w_nextDogPulse;
    logic              w_nextGameOver;

    logic              w_fireEdge;
    logic              w_reloadEdge;
    logic [N_TGT-1:0]  w_hitRaw;
    logic [N_TGT-1:0]  w_killVec;
    logic [CW-1:0]     w_space;
    logic [CW-1:0]     w_resExt;
    logic [CW-1:0]     w_xfer;

    assign w_fireEdge   = left_mouse  & ~r_leftPrev;
    assign w_reloadEdge = right_mouse & ~r_rightPrev;

    // Box test per target. Upper bounds are formed in 13 bits so a target near
    // the right/bottom edge of the 12-bit space does not wrap around to zero.
    always_comb begin
        w_hitRaw = '0;
        for (int i = 0; i < N_TGT; i++) begin
            w_hitRaw[i] = tgt_alive[i]
                && (mouse_xpos >= tgt_xpos[12*i +: 12])
                && ({1'b0, mouse_xpos} <= ({1'b0, tgt_xpos[12*i +: 12]} + 13'(TGT_W)))
                && (mouse_ypos >= tgt_ypos[12*i +: 12])
                && ({1'b0, mouse_ypos} <= ({1'b0, tgt_ypos[12*i +: 12]} + 13'(TGT_H)));
        end
    end

    // Isolate the lowest set bit so overlapping targets yield a single kill.
    assign w_killVec = w_hitRaw & (~w_hitRaw + N_TGT'(1));

    // Reload transfer amount: whatever fits in the magazine, limited by reserve.
    assign w_space  = CW'(MAG_SIZE) - CW'(r_mag);
    assign w_resExt = CW'(r_reserve);
    assign w_xfer   = (w_space < w_resExt) ? w_space : w_resExt;

    // State and datapath registers. Output flags are precomputed from the next
    // state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mag        <= MW'(MAG_SIZE);
            r_reserve    <= RW'(RESERVE);
            r_score      <= '0;
            r_timer      <= TW'(START_CYC);
            r_leftPrev   <= 1'b0;
            r_rightPrev  <= 1'b0;
            r_hitVec     <= '0;
            r_huntActive <= 1'b0;
            r_reloading  <= 1'b0;
            r_showReload <= 1'b0;
            r_dogPulse   <= 1'b0;
            r_gameOver   <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_mag        <= w_nextMag;
            r_reserve    <= w_nextReserve;
            r_score      <= w_nextScore;
            r_timer      <= w_nextTimer;
            r_leftPrev   <= left_mouse;
            r_rightPrev  <= right_mouse;
            r_hitVec     <= w_nextHitVec;
            r_huntActive <= w_nextHuntActive;
            r_reloading  <= w_nextReloading;
            r_showReload <= w_nextShowReload;
            r_dogPulse   <= w_nextDogPulse;
            r_gameOver   <= w_nextGameOver;
        end
    end

    // Next-state and counter logic. A fire edge always consumes the cycle, so a
    // reload edge arriving with it is dropped even when the magazine is empty.
    always_comb begin
        w_nextState   = r_state;
        w_nextMag     = r_mag;
        w_nextReserve = r_reserve;
        w_nextScore   = r_score;
        w_nextTimer   = r_timer;
        w_nextHitVec  = '0;
        case (r_state)
            S_IDLE: begin
                w_nextMag     = MW'(MAG_SIZE);
                w_nextReserve = RW'(RESERVE);
                w_nextScore   = '0;
                w_nextTimer   = TW'(START_CYC);
                if (game_enable) begin
                    w_nextState = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (r_timer == '0) begin
                    w_nextState = S_HUNTING;
                end else begin
                    w_nextTimer = r_timer - TW'(1);
                end
            end
            S_HUNTING: begin
                if (w_fireEdge) begin
                    if (r_mag != '0) begin
                        w_nextMag = r_mag - MW'(1);
                        if (w_killVec != '0) begin
                            w_nextHitVec = w_killVec;
                            w_nextScore  = (r_score == 7'd127) ? r_score : r_score + 7'd1;
                            w_nextTimer  = TW'(KILL_CYC);
                            w_nextState  = S_KILL_DELAY;
                        end else if ((r_mag == MW'(1)) && (r_reserve == '0)) begin
                            w_nextState = S_OVER;
                        end
                    end
                end else if (w_reloadEdge && (r_mag < MW'(MAG_SIZE)) && (r_reserve != '0)) begin
                    w_nextTimer = TW'(RELOAD_CYC);
                    w_nextState = S_RELOADING;
                end
            end
            S_RELOADING: begin
                if (r_timer == '0) begin
                    w_nextMag     = r_mag + MW'(w_xfer);
                    w_nextReserve = r_reserve - RW'(w_xfer);
                    w_nextState   = S_HUNTING;
                end else begin
                    w_nextTimer = r_timer - TW'(1);
                end
            end
            S_KILL_DELAY: begin
                // A kill with the very last round goes straight to OVER.
                if (r_timer == '0) begin
                    if ((r_mag == '0) && (r_reserve == '0)) begin
                        w_nextState = S_OVER;
                    end else begin
                        w_nextState = S_HUNTING;
                    end
                end else begin
                    w_nextTimer = r_timer - TW'(1);
                end
            end
            S_OVER: begin
                w_nextState = S_OVER;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        // Dropping game_enable aborts the round from anywhere.
        if ((r_state != S_IDLE) && !game_enable) begin
            w_nextState   = S_IDLE;
            w_nextMag     = MW'(MAG_SIZE);
            w_nextReserve = RW'(RESERVE);
            w_nextScore   = '0;
            w_nextTimer   = TW'(START_CYC);
            w_nextHitVec  = '0;
        end
    end

    // Output flags for the upcoming state. The dog pulse lands on the delay
    // cycle whose timer value equals DOG_CYC.
    always_comb begin
        w_nextHuntActive = (w_nextState == S_HUNTING) || (w_nextState == S_RELOADING);
        w_nextReloading  = (w_nextState == S_RELOADING);
        w_nextGameOver   = (w_nextState == S_OVER);
        w_nextShowReload = (w_nextMag == '0) && (w_nextState != S_OVER);
        w_nextDogPulse   = (w_nextState == S_KILL_DELAY) && (w_nextTimer == TW'(DOG_CYC));
    end

    assign mag         = r_mag;
    assign reserve     = r_reserve;
    assign score       = r_score;
    assign hit_vec     = r_hitVec;
    assign hunt_active = r_huntActive;
    assign reloading   = r_reloading;
    assign show_reload = r_showReload;
    assign dog_pulse   = r_dogPulse;
    assign game_over   = r_gameOver;

endmodule

// File: tb/tb_hunt_round_ctrl.sv
// tb_hunt_round_ctrl
// Self-checking bench for hunt_round_ctrl with short timer values. A behavioural
// game model (phases measured by elapsed cycles) predicts every output after
// every clock; directed scenarios walk through the round flow, then a long
// randomized run exercises hit boundaries, resets and enable drops.

module tb_hunt_round_ctrl;

    localparam int N_TGT      = 2;
    localparam int TGT_W      = 96;
    localparam int TGT_H      = 60;
    localparam int MAG_SIZE   = 3;
    localparam int RESERVE    = 4;
    localparam int START_CYC  = 10;
    localparam int KILL_CYC   = 8;
    localparam int DOG_CYC    = 4;
    localparam int RELOAD_CYC = 5;

    localparam int M_IDLE   = 0;
    localparam int M_COUNT  = 1;
    localparam int M_HUNT   = 2;
    localparam int M_RELOAD = 3;
    localparam int M_KILL   = 4;
    localparam int M_OVER   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        gameEnable;
    logic [11:0] mouseX;
    logic [11:0] mouseY;
    logic        leftMouse;
    logic        rightMouse;
    logic [23:0] tgtXpos;
    logic [23:0] tgtYpos;
    logic [1:0]  tgtAlive;
    logic [1:0]  mag;
    logic [2:0]  reserve;
    logic [6:0]  score;
    logic [1:0]  hitVec;
    logic        huntActive;
    logic        reloading;
    logic        showReload;
    logic        dogPulse;
    logic        gameOver;

    int tgtX [N_TGT];
    int tgtY [N_TGT];

    int mMode, mMag, mRes, mScore, mElapsed, mPrevL, mPrevR, expHit, expDog;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    hunt_round_ctrl #(
        .N_TGT(N_TGT), .TGT_W(TGT_W), .TGT_H(TGT_H), .MAG_SIZE(MAG_SIZE),
        .RESERVE(RESERVE), .START_CYC(START_CYC), .KILL_CYC(KILL_CYC),
        .DOG_CYC(DOG_CYC), .RELOAD_CYC(RELOAD_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .game_enable(gameEnable),
        .mouse_xpos(mouseX),
        .mouse_ypos(mouseY),
        .left_mouse(leftMouse),
        .right_mouse(rightMouse),
        .tgt_xpos(tgtXpos),
        .tgt_ypos(tgtYpos),
        .tgt_alive(tgtAlive),
        .mag(mag),
        .reserve(reserve),
        .score(score),
        .hit_vec(hitVec),
        .hunt_active(huntActive),
        .reloading(reloading),
        .show_reload(showReload),
        .dog_pulse(dogPulse),
        .game_over(gameOver)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStartRound();
        mMag     = MAG_SIZE;
        mRes     = RESERVE;
        mScore   = 0;
        mElapsed = 0;
    endtask

    // One clock of the game rules, using the inputs present at the edge.
    task automatic modelStep();
        int fire, reload, victim, room, take;
        fire   = (leftMouse  && !mPrevL) ? 1 : 0;
        reload = (rightMouse && !mPrevR) ? 1 : 0;
        mPrevL = leftMouse  ? 1 : 0;
        mPrevR = rightMouse ? 1 : 0;
        expHit = 0;
        expDog = 0;
        if (rst) begin
            mMode  = M_IDLE;
            mPrevL = 0;
            mPrevR = 0;
            modelStartRound();
        end else if (mMode != M_IDLE && !gameEnable) begin
            mMode = M_IDLE;
            modelStartRound();
        end else begin
            case (mMode)
                M_IDLE: begin
                    modelStartRound();
                    if (gameEnable) mMode = M_COUNT;
                end
                M_COUNT: begin
                    if (mElapsed == START_CYC) mMode = M_HUNT;
                    else mElapsed++;
                end
                M_HUNT: begin
                    if (fire == 1) begin
                        if (mMag > 0) begin
                            mMag--;
                            victim = -1;
                            for (int i = 0; i < N_TGT; i++) begin
                                if (victim < 0 && tgtAlive[i]
                                    && int'(mouseX) >= tgtX[i] && int'(mouseX) <= tgtX[i] + TGT_W
                                    && int'(mouseY) >= tgtY[i] && int'(mouseY) <= tgtY[i] + TGT_H)
                                    victim = i;
                            end
                            if (victim >= 0) begin
                                expHit   = 1 << victim;
                                mScore   = (mScore >= 127) ? 127 : mScore + 1;
                                mMode    = M_KILL;
                                mElapsed = 0;
                            end else if (mMag == 0 && mRes == 0) begin
                                mMode = M_OVER;
                            end
                        end
                    end else if (reload == 1 && mMag < MAG_SIZE && mRes > 0) begin
                        mMode    = M_RELOAD;
                        mElapsed = 0;
                    end
                end
                M_RELOAD: begin
                    if (mElapsed == RELOAD_CYC) begin
                        room = MAG_SIZE - mMag;
                        take = (room < mRes) ? room : mRes;
                        mMag += take;
                        mRes -= take;
                        mMode = M_HUNT;
                    end else begin
                        mElapsed++;
                    end
                end
                M_KILL: begin
                    if (mElapsed == KILL_CYC) begin
                        mMode = (mMag == 0 && mRes == 0) ? M_OVER : M_HUNT;
                    end else begin
                        mElapsed++;
                        if (mElapsed == KILL_CYC - DOG_CYC) expDog = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compareAll();
        checkOutput("mag",         int'(mag),        mMag);
        checkOutput("reserve",     int'(reserve),    mRes);
        checkOutput("score",       int'(score),      mScore);
        checkOutput("hit_vec",     int'(hitVec),     expHit);
        checkOutput("hunt_active", int'(huntActive), (mMode == M_HUNT || mMode == M_RELOAD) ? 1 : 0);
        checkOutput("reloading",   int'(reloading),  (mMode == M_RELOAD) ? 1 : 0);
        checkOutput("show_reload", int'(showReload), (mMag == 0 && mMode != M_OVER) ? 1 : 0);
        checkOutput("dog_pulse",   int'(dogPulse),   expDog);
        checkOutput("game_over",   int'(gameOver),   (mMode == M_OVER) ? 1 : 0);
    endtask

    // Drive one cycle of inputs, clock it, advance the model, compare #1 later.
    task automatic applyStimulus(input logic r, input logic ge, input logic l, input logic rm);
        rst        = r;
        gameEnable = ge;
        leftMouse  = l;
        rightMouse = rm;
        for (int i = 0; i < N_TGT; i++) begin
            tgtXpos[12*i +: 12] = 12'(tgtX[i]);
            tgtYpos[12*i +: 12] = 12'(tgtY[i]);
        end
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    function automatic int pickNear(input int base, input int span);
        int v;
        case ($urandom_range(0, 7))
            0: v = base - 1;
            1: v = base;
            2: v = base + 1;
            3: v = base + span - 1;
            4: v = base + span;
            5: v = base + span + 1;
            6: v = int'($urandom_range(0, 4095));
            default: v = base + int'($urandom_range(0, span));
        endcase
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        return v;
    endfunction

    initial begin
        int cyc, dogAt, backAt, dogSeen, j;
        mMode = M_IDLE; mPrevL = 0; mPrevR = 0; expHit = 0; expDog = 0;
        modelStartRound();
        mouseX = 12'd0; mouseY = 12'd0; tgtAlive = 2'b00;
        for (int i = 0; i < N_TGT; i++) begin tgtX[i] = 0; tgtY[i] = 0; end

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_mag", int'(mag), 3);
        checkOutput("rst_reserve", int'(reserve), 4);
        checkOutput("rst_score", int'(score), 0);

        // Countdown latency from enable to hunting.
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (huntActive) begin cyc = k; break; end
        end
        checkOutput("start_latency", cyc, 12);

        // One click inside two overlapping targets kills only target 0.
        tgtX[0] = 100; tgtY[0] = 100; tgtX[1] = 120; tgtY[1] = 110;
        tgtAlive = 2'b11; mouseX = 12'd150; mouseY = 12'd130;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("overlap_hit", int'(hitVec), 1);
        checkOutput("overlap_score", int'(score), 1);
        checkOutput("overlap_mag", int'(mag), 2);
        dogAt = 0; backAt = 0;
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (dogPulse && dogAt == 0) dogAt = k;
            if (huntActive) begin backAt = k; break; end
        end
        checkOutput("dog_delay", dogAt, 4);
        checkOutput("kill_return", backAt, 9);

        // Held fire is one shot; then empty the magazine.
        tgtAlive = 2'b00;
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("held_fire_mag", int'(mag), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("empty_show_reload", int'(showReload), 1);

        // Reload from empty.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("reload_start", int'(reloading), 1);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("reload_mag", int'(mag), 3);
        checkOutput("reload_reserve", int'(reserve), 1);

        // Fire and reload together: shot taken, reload dropped.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("both_mag", int'(mag), 2);
        checkOutput("both_reloading", int'(reloading), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("fire_in_reload_mag", int'(mag), 2);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("partial_reload_mag", int'(mag), 3);
        checkOutput("partial_reload_res", int'(reserve), 0);

        // Spend the last three rounds on misses.
        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("over_flag", int'(gameOver), 1);
        checkOutput("over_show_reload", int'(showReload), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_mag", int'(mag), 3);
        checkOutput("idle_reserve", int'(reserve), 4);
        checkOutput("idle_score", int'(score), 0);

        // Reset in the middle of a kill delay.
        repeat (13) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tgtAlive = 2'b10;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("kill_tgt1", int'(hitVec), 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_kd_hunt", int'(huntActive), 0);
        checkOutput("rst_kd_score", int'(score), 0);
        checkOutput("rst_kd_mag", int'(mag), 3);
        dogSeen = 0;
        repeat (12) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (dogPulse) dogSeen++;
        end
        checkOutput("no_dog_after_rst", dogSeen, 0);

        // Randomized play.
        for (int n = 0; n < 5000; n++) begin
            if (n % 16 == 0) begin
                tgtX[0] = int'($urandom_range(0, 4095));
                tgtY[0] = int'($urandom_range(0, 4095));
                if ($urandom_range(0, 1) == 0) begin
                    tgtX[1] = pickNear(tgtX[0], 40);
                    tgtY[1] = pickNear(tgtY[0], 30);
                end else begin
                    tgtX[1] = int'($urandom_range(0, 4095));
                    tgtY[1] = int'($urandom_range(0, 4095));
                end
            end
            j = int'($urandom_range(0, N_TGT - 1));
            mouseX   = 12'(pickNear(tgtX[j], TGT_W));
            mouseY   = 12'(pickNear(tgtY[j], TGT_H));
            tgtAlive = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 499) == 0),
                          ($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/hunt_round_ctrl.md
HUNT_ROUND_CTRL -- requirements
Module: hunt_round_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- N_TGT, 2, number of targets
- TGT_W, 96, target box width in px
- TGT_H, 60, target box height in px
- MAG_SIZE, 3, magazine capacity
- RESERVE, 15, initial reserve rounds
- START_CYC, 487_500_000, countdown cycles
- KILL_CYC, 292_500_000, post-kill delay cycles
- DOG_CYC, 162_500_000, kill-timer value that fires dog pulse; DOG_CYC < KILL_CYC
- RELOAD_CYC, 32_500_000, reload duration in cycles
REQ-002 SHALL have ports (name, direction, width, meaning), one per line; MW = $clog2(MAG_SIZE+1), RW = $clog2(RESERVE+1):
- clk, in, 1, clock, posedge
- rst, in, 1, reset, synchronous, active-high
- game_enable, in, 1, game running
- mouse_xpos, in, 12, cursor x
- mouse_ypos, in, 12, cursor y
- left_mouse, in, 1, fire, level
- right_mouse, in, 1, reload, level
- tgt_xpos, in, 12*N_TGT, target i x at [12i+11:12i]
- tgt_ypos, in, 12*N_TGT, target i y at [12i+11:12i]
- tgt_alive, in, N_TGT, target i hittable
- mag, out, MW, rounds in magazine
- reserve, out, RW, reserve rounds
- score, out, 7, kills, saturating
- hit_vec, out, N_TGT, one-hot kill pulse
- hunt_active, out, 1, high in HUNTING/RELOADING
- reloading, out, 1, high in RELOADING
- show_reload, out, 1, mag==0
- dog_pulse, out, 1, one-cycle dog trigger
- game_over, out, 1, high in OVER

Function
REQ-003 SHALL detect left/right press as rising edge versus a registered previous sample; level hold SHALL NOT repeat.
REQ-004 SHALL have states IDLE, COUNTDOWN, HUNTING, RELOADING, KILL_DELAY, OVER; all outputs registered.
REQ-005 IDLE: mag=MAG_SIZE, reserve=RESERVE, score=0, timer=START_CYC; game_enable=1 -> COUNTDOWN next cycle.
REQ-006 COUNTDOWN: timer decrements by 1 per cycle; at timer==0 -> HUNTING; clicks ignored.
REQ-007 HUNTING fire edge with mag>0: mag decrements by 1; hit test on target i: tgt_alive[i] and mouse_x in [x_i, x_i+TGT_W] and mouse_y in [y_i, y_i+TGT_H], inclusive, 13-bit compare without wrap.
REQ-008 Several targets hit by one shot: only the lowest index SHALL be killed; hit_vec one-hot for 1 cycle on the cycle after the edge; score+1, saturating at 127; timer=KILL_CYC; -> KILL_DELAY.
REQ-009 Fire edge with mag==0 SHALL be ignored; no state or counter change.
REQ-010 HUNTING reload edge with mag<MAG_SIZE and reserve>0 -> RELOADING, timer=RELOAD_CYC; otherwise ignored.
REQ-011 Fire and reload edges in the same cycle: fire SHALL take priority; the reload edge is dropped.
REQ-012 RELOADING: fire edges ignored; timer decrements; at timer==0, T=min(MAG_SIZE-mag, reserve); mag+=T, reserve-=T; -> HUNTING.
REQ-013 KILL_DELAY: timer decrements; dog_pulse=1 for exactly the cycle timer==DOG_CYC; at 0 -> HUNTING; clicks ignored.
REQ-014 Entering HUNTING with mag==0 and reserve==0, or a non-killing shot leaving mag==0 with reserve==0 -> OVER; a killing last shot -> KILL_DELAY, then OVER.
REQ-015 OVER: counters frozen, game_over=1; game_enable=0 -> IDLE.
REQ-016 game_enable=0 in any non-IDLE state -> IDLE next cycle; no pulses fire that cycle.
REQ-017 show_reload = (mag==0) and not OVER; reloading = (state==RELOADING).

Reset
REQ-018 rst SHALL force IDLE, mag=MAG_SIZE, reserve=RESERVE, score=0, timer=START_CYC, hit_vec=0, dog_pulse=0, game_over=0, hunt_active=0, reloading=0, show_reload=0, edge registers=0, regardless of the current state.

Verification (N_TGT=2, START_CYC=10, KILL_CYC=8, DOG_CYC=4, RELOAD_CYC=5, MAG_SIZE=3, RESERVE=4)
REQ-019 game_enable=1 -> hunt_active rises 12 cycles after enable, +/-1 per registered stage; held fire -> one shot only.
REQ-020 Overlapping targets 0 and 1, click inside both -> hit_vec=01, score=1, mag=2; dog_pulse 4 cycles into delay; HUNTING after 8.
REQ-021 Three misses then reload -> show_reload=1; after 5 cycles mag=3, reserve=1; second empty+reload -> mag=1, reserve=0.
REQ-022 Fire and reload in the same cycle -> shot counted, no reload; fire during RELOADING -> mag unchanged.
REQ-023 Exhaust all 7 rounds by missing -> game_over=1; drop game_enable -> IDLE with mag=3, reserve=4, score=0.
REQ-024 rst during KILL_DELAY -> all outputs at reset values next cycle; dog_pulse never fires.
